// File: rtl/lstm_gate_mac.sv
// rtl/lstm_gate_mac.sv - serial MAC computing one saturated Q7.24 LSTM gate pre-activation
module lstm_gate_mac #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 24,
    parameter int N         = 8,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_w,
    output logic             o_ready,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_z,
    output logic             o_valid,
    input  logic             i_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_WIDTH-1:0]   cnt;
    logic        [WIDTH-1:0]       bias;
    logic                          beat;
    logic                          last_beat;
    logic signed [2*WIDTH-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]   term;
    logic signed [ACC_WIDTH-1:0]   total;
    logic                          fits;
    logic        [WIDTH-1:0]       z_sat;

    assign o_ready   = (state == ACC);
    assign o_busy    = (state != IDLE);
    assign beat      = i_valid && o_ready;
    assign last_beat = beat && (cnt == CNT_WIDTH'(N - 1));

    // Full-precision product, rescaled back to Q7.24 by an arithmetic shift
    // (floor rounding); the accumulator is wide enough that no term overflows.
    assign prod  = $signed(i_x) * $signed(i_w);
    assign term  = ACC_WIDTH'(prod >>> FRAC);
    assign total = acc + {{(ACC_WIDTH - WIDTH){bias[WIDTH-1]}}, bias};

    // Clamp to the WIDTH-bit signed range only at the output; the value fits
    // when every bit above the result sign bit matches the sign bit.
    always_comb begin
        fits  = (&total[ACC_WIDTH-1:WIDTH-1]) || !(|total[ACC_WIDTH-1:WIDTH-1]);
        z_sat = total[WIDTH-1:0];
        if (!fits) begin
            if (total[ACC_WIDTH-1]) begin
                z_sat = {1'b1, {(WIDTH - 1){1'b0}}};
            end else begin
                z_sat = {1'b0, {(WIDTH - 1){1'b1}}};
            end
        end
    end

    // Next-state selection: start from IDLE, last beat ends ACC, handshake ends DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_start) state_next = ACC;
            ACC:  if (last_beat) state_next = DONE;
            DONE: if (o_valid && i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus datapath: bias latch, accumulation, result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            bias    <= '0;
            o_z     <= '0;
            o_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        bias <= i_b;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= acc + term;
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; it then holds until taken.
                    if (!o_valid) begin
                        o_z     <= z_sat;
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_gate_mac.sv
// tb/tb_lstm_gate_mac.sv - scoreboard bench for lstm_gate_mac with N=4
module tb_lstm_gate_mac;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam longint ZMAX = 64'sd2147483647;
    localparam longint ZMIN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_b;
    logic             i_valid;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_w;
    logic             o_ready;
    logic             o_busy;
    logic [WIDTH-1:0] o_z;
    logic             o_valid;
    logic             i_ready;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               edges;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] xs[N];
    logic [WIDTH-1:0] ws[N];

    lstm_gate_mac #(.WIDTH(WIDTH), .FRAC(24), .N(N), .ACC_WIDTH(48), .CNT_WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_b     (i_b),
        .i_valid (i_valid),
        .i_x     (i_x),
        .i_w     (i_w),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_z     (o_z),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic fill(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] w);
        for (int k = 0; k < N; k++) begin
            xs[k] = x;
            ws[k] = w;
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] b);
        longint acc = 0;
        longint z;
        for (int k = 0; k < N; k++) begin
            acc += (longint'($signed(xs[k])) * longint'($signed(ws[k]))) >>> 24;
        end
        z = acc + longint'($signed(b));
        if (z > ZMAX) return 32'h7FFF_FFFF;
        if (z < ZMIN) return 32'h8000_0000;
        return z[WIDTH-1:0];
    endfunction

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() > 0) check_eq("z", {32'b0, o_z}, {32'b0, exp_q.pop_front()});
            else check_eq("spurious_valid", {63'b0, o_valid}, 64'd0);
        end
    end

    task automatic run_gate(input logic [WIDTH-1:0] b, input int gap, input int hold, input bit noise);
        logic [WIDTH-1:0] zh;
        int t;
        exp_q.push_back(model(b));
        i_start = 1'b1;
        i_b     = b;
        edges   = -1;
        step();
        i_start = 1'b0;
        i_b     = $urandom;
        check_eq("busy_acc", {63'b0, o_busy}, 64'd1);
        check_eq("ready_acc", {63'b0, o_ready}, 64'd1);
        for (int k = 0; k < N; k++) begin
            i_valid = 1'b1;
            i_x     = xs[k];
            i_w     = ws[k];
            step();
            i_valid = 1'b0;
            i_x     = $urandom;
            i_w     = $urandom;
            if (k < N - 1) begin
                repeat (gap) begin
                    i_start = noise;
                    step();
                end
                i_start = 1'b0;
            end
        end
        check_eq("ready_done", {63'b0, o_ready}, 64'd0);
        i_ready = (hold == 0);
        if (noise) begin
            i_start = 1'b1;
            i_valid = 1'b1;
        end
        t = 0;
        while (!o_valid && t < 20) begin
            step();
            t++;
        end
        check_eq("latency", 64'(edges), 64'(N + 1 + gap * (N - 1)));
        if (hold > 0) begin
            zh = o_z;
            repeat (hold) step();
            check_eq("hold_valid", {63'b0, o_valid}, 64'd1);
            check_eq("hold_z", {32'b0, o_z}, {32'b0, zh});
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        check_eq("valid_drop", {63'b0, o_valid}, 64'd0);
        check_eq("idle", {63'b0, o_busy}, 64'd0);
        check_eq("period", 64'(edges), 64'(N + 2 + gap * (N - 1) + hold));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_b     = '0;
        i_valid = 1'b0;
        i_x     = '0;
        i_w     = '0;
        i_ready = 1'b1;
        edges   = 0;
        repeat (2) step();
        check_eq("rst_z", {32'b0, o_z}, 64'd0);
        check_eq("rst_valid", {63'b0, o_valid}, 64'd0);
        check_eq("rst_ready", {63'b0, o_ready}, 64'd0);
        check_eq("rst_busy", {63'b0, o_busy}, 64'd0);
        rst_n = 1'b1;
        step();

        fill(32'h0100_0000, 32'h0080_0000);
        run_gate(32'h0000_0000, 0, 0, 1'b0);
        fill(32'hFF00_0000, 32'h0040_0000);
        run_gate(32'h0033_3333, 0, 0, 1'b0);
        fill(32'hFFFF_FFFF, 32'h0000_0001);
        run_gate(32'h0000_0000, 0, 0, 1'b0);
        fill(32'h7F00_0000, 32'h7F00_0000);
        run_gate(32'h0000_0000, 0, 0, 1'b0);
        fill(32'h8100_0000, 32'h7F00_0000);
        run_gate(32'h0000_0000, 0, 0, 1'b0);

        fill(32'h0100_0000, 32'h0080_0000);
        run_gate(32'h0010_0000, 2, 0, 1'b1);
        fill(32'hFF00_0000, 32'h0040_0000);
        run_gate(32'h0033_3333, 1, 3, 1'b1);

        // Abort after two beats; nothing may be emitted for this evaluation.
        i_start = 1'b1;
        i_b     = 32'h0500_0000;
        step();
        i_start = 1'b0;
        fill(32'h0200_0000, 32'h0300_0000);
        for (int k = 0; k < 2; k++) begin
            i_valid = 1'b1;
            i_x     = xs[k];
            i_w     = ws[k];
            step();
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        step();
        check_eq("abort_busy", {63'b0, o_busy}, 64'd0);
        check_eq("abort_valid", {63'b0, o_valid}, 64'd0);
        check_eq("abort_z", {32'b0, o_z}, 64'd0);
        rst_n = 1'b1;
        repeat (5) step();
        check_eq("abort_quiet", {63'b0, o_valid}, 64'd0);
        fill(32'h0100_0000, 32'h0080_0000);
        run_gate(32'h0000_0000, 0, 0, 1'b0);

        // Back-to-back with random operands.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                xs[k] = $urandom;
                ws[k] = $urandom_range(0, 32'h01FF_FFFF);
            end
            run_gate($urandom, 0, 0, 1'b0);
        end

        step();
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
